// File: rtl/gpio_io_pkg.sv
// Shared types and the hex-digit segment table for the board GPIO block.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package gpio_io_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/gpio_io_ctrl_sw_debounce.sv
// Synchronises the raw switches into the clock domain and only accepts a new
// switch word once it has held still for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sw_s;
  logic [WIDTH-1:0]                  sw_prev;
  logic [CW-1:0]                     count;

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  // The edge where sw_s first differs restarts the count, so accepting at
  // DEBOUNCE_CYCLES-2 means the new word has been seen on DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_prev <= '0;
      stable  <= '0;
      count   <= '0;
    end else begin
      sw_prev <= sw_s;
      if (sw_s != sw_prev) begin
        count <= '0;
      end else if (sw_s != stable) begin
        if (count == LAST) begin
          stable <= sw_s;
          count  <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_io_ctrl.sv
// Board-side GPIO: debounced switches toward the core, and the core's output
// word shown on LEDs plus an 8-digit multiplexed hex display.
module gpio_io_ctrl
  import gpio_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REFRESH_CYCLES  = 1000,
  parameter int BLANK_CYCLES    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sw,
  output logic [31:0] gpio_in,
  input  logic [31:0] gpio_out,
  output logic [17:0] led,
  output logic [6:0]  hex_seg,
  output logic [7:0]  hex_sel,
  output logic [7:0]  change_cnt
);

  localparam int TMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] BLANK_LAST   = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] REFRESH_LAST = TW'(REFRESH_CYCLES - 1);

  logic [17:0]   sw_stable;
  logic [31:0]   disp;
  scan_state_t   state;
  logic [TW-1:0] timer;
  logic [2:0]    digit;

  sw_debounce #(
    .WIDTH           (18),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .stable (sw_stable)
  );

  assign gpio_in = {14'd0, sw_stable};
  assign led     = disp[17:0];

  // Only a real value change counts; the core rewriting the same word is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp       <= '0;
      change_cnt <= '0;
    end else if (gpio_out != disp) begin
      disp       <= gpio_out;
      change_cnt <= change_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BLANK;
      timer   <= '0;
      digit   <= '0;
      hex_sel <= 8'hFF;
      hex_seg <= 7'h7F;
    end else begin
      case (state)
        BLANK: begin
          hex_sel <= 8'hFF;
          hex_seg <= 7'h7F;
          if (timer == BLANK_LAST) begin
            state <= DRIVE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRIVE: begin
          hex_sel <= ~(8'b1 << digit);
          hex_seg <= seg_decode(disp[{digit, 2'b00} +: 4]);
          if (timer == REFRESH_LAST) begin
            state <= BLANK;
            timer <= '0;
            digit <= digit + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
